// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: controller-side request/response plus the
// word-wide synchronous memory port.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata,
    output busy, done, misaligned, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input  busy, done, misaligned, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Word/half/byte load-store engine in front of a fixed-latency synchronous memory.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted and extended.
//
// state | meaning
// IDLE  | waiting for req; alignment checked here
// ISSUE | memory strobe active (read, or write for a word store)
// WAIT  | counting down the read latency, mem_rdata captured on terminal count
// WRITE | merged word written back for a sub-word store
// DONE  | one-cycle completion pulse
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        sx_q;
  logic        mis_q;
  logic [31:0] rdata_q;
  logic        mem_en_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic        mem_en_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic        mis_req;
  logic        accept;
  logic        rd_tc;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    mis_req     = (bus.size == 2'b11) ||
                  (bus.size == 2'b01 && bus.addr[0]) ||
                  (bus.size == 2'b00 && bus.addr[1:0] != 2'b00);
    accept      = (state_q == IDLE) && bus.req;
    rd_tc       = (state_q == WAIT) && (cnt_q == 3'd1);

    byte_v      = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    half_v      = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = bus.mem_rdata;
      2'b01:   load_val = {{16{sx_q & half_v[15]}}, half_v};
      default: load_val = {{24{sx_q & byte_v[7]}}, byte_v};
    endcase

    merge_val   = bus.mem_rdata;
    if (size_q == 2'b01) begin
      if (lane_q[1]) merge_val[31:16] = wdata_q;
      else           merge_val[15:0]  = wdata_q;
    end else begin
      merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // mem_* are registered, so they are computed from the transition into ISSUE/WRITE
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (mis_req) begin
            state_d = DONE;
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.we && (bus.size == 2'b00);
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_wdata_d = bus.wdata;
          end
        end
      end
      ISSUE: state_d = (we_q && size_q == 2'b00) ? DONE : WAIT;
      WAIT: begin
        if (cnt_q == 3'd1) begin
          if (we_q) begin
            state_d     = WRITE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = merge_val;
          end else begin
            state_d = DONE;
          end
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      size_q      <= 2'b00;
      we_q        <= 1'b0;
      sx_q        <= 1'b0;
      mis_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        lane_q  <= bus.addr[1:0];
        wdata_q <= bus.wdata[15:0];
        size_q  <= bus.size;
        we_q    <= bus.we;
        sx_q    <= bus.sign_ext;
        mis_q   <= mis_req;
      end
      if (state_q == ISSUE)     cnt_q <= 3'(MEM_LATENCY);
      else if (state_q == WAIT) cnt_q <= cnt_q - 3'd1;
      if (rd_tc && !we_q) rdata_q <= load_val;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.misaligned = (state_q == DONE) && mis_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a latency-LAT synchronous word memory model.
module tb_mem_access_unit;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_LATENCY(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem  [64];
  logic [31:0] pipe [LAT];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One request; inputs are scrambled after the req cycle to prove they were latched.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_k,
                        input logic exp_mis, input int exp_en, input logic [31:0] exp_rd);
    int k;
    int en_cnt;
    logic [31:0] first_addr;
    logic got;
    logic mis_seen;
    k = 0; en_cnt = 0; first_addr = '0; got = 1'b0; mis_seen = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.req = 1'b0; bus.addr = ~a; bus.wdata = ~wd; end
      if (bus.mem_en) begin
        if (en_cnt == 0) first_addr = bus.mem_addr;
        en_cnt++;
      end
      if (bus.done) begin got = 1'b1; k = i; mis_seen = bus.misaligned; end
    end
    check_val({tag, ":done_cyc"}, k, exp_k);
    check_val({tag, ":mis"}, {31'b0, mis_seen}, {31'b0, exp_mis});
    check_val({tag, ":mem_en_cnt"}, en_cnt, exp_en);
    if (exp_en > 0) check_val({tag, ":mem_addr"}, first_addr, {a[31:2], 2'b00});
    check_val({tag, ":rdata"}, bus.rdata, exp_rd);
    @(negedge clk);
    check_val({tag, ":idle"}, {30'b0, bus.busy, bus.done}, 32'h0);
  endtask

  initial begin
    int dcnt;
    int d1, d2;
    int en_cnt;
    logic [31:0] rd1, rd2;

    reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    #1;
    check_val("rst_ctl", {27'b0, bus.busy, bus.done, bus.misaligned, bus.mem_en, bus.mem_we}, 32'h0);
    check_val("rst_rdata", bus.rdata, 32'h0);
    check_val("rst_maddr", bus.mem_addr, 32'h0);
    check_val("rst_mwdata", bus.mem_wdata, 32'h0);

    preload(6'd16, 32'h80FF_7F01);
    preload(6'd8,  32'h1122_3344);
    preload(6'd4,  32'h0000_0000);
    preload(6'd20, 32'h1357_9BDF);
    preload(6'd21, 32'h2468_ACE0);
    @(negedge clk);
    reset = 1'b1;

    // loads of 0x80FF7F01
    access("lb_s_43", 1'b0, 2'b10, 1'b1, 32'h0000_0043, 32'h0, 2+LAT, 1'b0, 1, 32'hFFFF_FF80);
    access("lbu_42",  1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 2+LAT, 1'b0, 1, 32'h0000_00FF);
    access("lh_s_40", 1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0, 2+LAT, 1'b0, 1, 32'h0000_7F01);
    access("lh_s_42", 1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0, 2+LAT, 1'b0, 1, 32'hFFFF_80FF);
    access("lw_40",   1'b0, 2'b00, 1'b1, 32'h0000_0040, 32'h0, 2+LAT, 1'b0, 1, 32'h80FF_7F01);

    // stores; rdata must not move
    access("sw_10", 1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 1, 32'h80FF_7F01);
    check_val("sw_10:mem", mem[4], 32'hDEAD_BEEF);
    access("sb_21", 1'b1, 2'b10, 1'b0, 32'h0000_0021, 32'h0000_00AB, 3+LAT, 1'b0, 2, 32'h80FF_7F01);
    check_val("sb_21:mem", mem[8], 32'h1122_AB44);
    access("sh_22", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_CAFE, 3+LAT, 1'b0, 2, 32'h80FF_7F01);
    check_val("sh_22:mem", mem[8], 32'hCAFE_AB44);

    // misaligned / illegal: no memory traffic, rdata unchanged
    access("lw_mis_42", 1'b0, 2'b00, 1'b0, 32'h0000_0042, 32'h0, 1, 1'b1, 0, 32'h80FF_7F01);
    access("sz11_40",   1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 1, 1'b1, 0, 32'h80FF_7F01);
    access("lh_mis_41", 1'b0, 2'b01, 1'b1, 32'h0000_0041, 32'h0, 1, 1'b1, 0, 32'h80FF_7F01);
    access("sw_mis_12", 1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h5555_5555, 1, 1'b1, 0, 32'h80FF_7F01);
    check_val("sw_mis_12:mem", mem[4], 32'hDEAD_BEEF);

    // req held high across two loads
    d1 = 0; d2 = 0; dcnt = 0; en_cnt = 0; rd1 = '0; rd2 = '0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0; bus.addr = 32'h0000_0050;
    for (int i = 1; i <= 30 && dcnt < 2; i++) begin
      @(negedge clk);
      if (i == 1) bus.addr = 32'h0000_0054;
      if (bus.mem_en) en_cnt++;
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = i; rd1 = bus.rdata; end
        else begin d2 = i; rd2 = bus.rdata; bus.req = 1'b0; end
      end
    end
    bus.req = 1'b0;
    check_val("b2b:done1_cyc", d1, 2+LAT);
    check_val("b2b:done2_cyc", d2, 2*(2+LAT)+1);
    check_val("b2b:rdata1", rd1, 32'h1357_9BDF);
    check_val("b2b:rdata2", rd2, 32'h2468_ACE0);
    check_val("b2b:mem_en_cnt", en_cnt, 2);
    @(negedge clk);
    check_val("b2b:idle", {30'b0, bus.busy, bus.done}, 32'h0);

    // reset mid-WAIT of a load
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b00; bus.addr = 32'h0000_0040;
    @(negedge clk);
    bus.req = 1'b0;
    check_val("rstw:issue_en", {31'b0, bus.mem_en}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("rstw:ctl", {27'b0, bus.busy, bus.done, bus.misaligned, bus.mem_en, bus.mem_we}, 32'h0);
    check_val("rstw:rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // reset during ISSUE drops mem_en without a clock edge
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 32'h0000_0040;
    @(negedge clk);
    bus.req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("rsti:mem_en", {31'b0, bus.mem_en}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check_val("rsti:no_done", dcnt, 0);
    reset = 1'b1;
    for (int i = 0; i < 2 + LAT; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check_val("rsti:no_done_after", dcnt, 0);

    access("post_rst_lb", 1'b0, 2'b10, 1'b1, 32'h0000_0043, 32'h0, 2+LAT, 1'b0, 1, 32'hFFFF_FF80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
